// File: rtl/regfile_dbg_pkg.sv
// tinymips_pkg: shared register-file widths, types and the dump FSM state encoding.
`default_nettype none
package tinymips_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } dump_state_t;
endpackage
`default_nettype wire

// File: rtl/regfile_dbg_if.sv
// regfile_dbg_if: read/write ports and the debug dump channel of the register file.
`default_nettype none
interface regfile_dbg_if
  import tinymips_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
);
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] a3;
  logic [DATA_W-1:0] wd3;
  logic              we3;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              dump_req;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_done;
  logic              dump_busy;

  modport master (
    output a1, a2, a3, wd3, we3, dump_req, dump_ready,
    input  rd1, rd2, dump_valid, dump_addr, dump_data, dump_done, dump_busy
  );

  modport slave (
    input  a1, a2, a3, wd3, we3, dump_req, dump_ready,
    output rd1, rd2, dump_valid, dump_addr, dump_data, dump_done, dump_busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_dbg_dump_fsm.sv
// regfile_dump_fsm: walks every register and presents a stable snapshot beat over valid/ready.
`default_nettype none
module regfile_dump_fsm
  import tinymips_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  wire logic              clk_i,
  input  wire logic              rst_ni,
  input  wire logic              dump_req_i,
  input  wire logic              dump_ready_i,
  input  wire logic              we_i,
  input  wire logic [ADDR_W-1:0] a3_i,
  input  wire logic [DATA_W-1:0] wd3_i,
  output logic      [ADDR_W-1:0] dump_raddr_o,
  input  wire logic [DATA_W-1:0] dump_rdata_i,
  output logic                   dump_valid_o,
  output logic      [ADDR_W-1:0] dump_addr_o,
  output logic      [DATA_W-1:0] dump_data_o,
  output logic                   dump_done_o,
  output logic                   dump_busy_o
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_t       state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              done_q;
  logic              busy_q;

  assign dump_raddr_o = idx_q;
  assign dump_valid_o = valid_q;
  assign dump_addr_o  = addr_q;
  assign dump_data_o  = data_q;
  assign dump_done_o  = done_q;
  assign dump_busy_o  = busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dump_req_i) begin
            state_q <= LOAD;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          // The array still holds the old value on this edge, so fold in a coincident write.
          data_q  <= (we_i && (a3_i == idx_q)) ? wd3_i : dump_rdata_i;
          addr_q  <= idx_q;
          valid_q <= 1'b1;
          state_q <= SEND;
        end
        SEND: begin
          if (valid_q && dump_ready_i) begin
            valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= LOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/regfile_dbg.sv
// regfile_dbg: 2-read/1-write register file with a debug dump engine on a third internal read port.
`default_nettype none
module regfile_dbg #(
  parameter int NUM_REGS    = 32,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int HARDWIRE_R0 = 0
) (
  input wire logic     clk_i,
  input wire logic     rst_ni,
  regfile_dbg_if.slave rf
);
  import tinymips_pkg::*;

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              wr_en;
  logic [ADDR_W-1:0] dump_raddr;
  logic [DATA_W-1:0] dump_rdata;

  assign wr_en = rf.we3 && !((HARDWIRE_R0 != 0) && (rf.a3 == '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[rf.a3] <= rf.wd3;
    end
  end

  assign rf.rd1     = ((HARDWIRE_R0 != 0) && (rf.a1 == '0)) ? '0 : mem_q[rf.a1];
  assign rf.rd2     = ((HARDWIRE_R0 != 0) && (rf.a2 == '0)) ? '0 : mem_q[rf.a2];
  assign dump_rdata = mem_q[dump_raddr];

  regfile_dump_fsm #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_dump_fsm (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .dump_req_i   (rf.dump_req),
    .dump_ready_i (rf.dump_ready),
    .we_i         (wr_en),
    .a3_i         (rf.a3),
    .wd3_i        (rf.wd3),
    .dump_raddr_o (dump_raddr),
    .dump_rdata_i (dump_rdata),
    .dump_valid_o (rf.dump_valid),
    .dump_addr_o  (rf.dump_addr),
    .dump_data_o  (rf.dump_data),
    .dump_done_o  (rf.dump_done),
    .dump_busy_o  (rf.dump_busy)
  );
endmodule
`default_nettype wire

// File: doc/regfile_dbg.md
Name: regfile_dbg

Overview:
- 3-port MIPS register file: two combinational read ports and one synchronous write port.
- Adds a debug dump engine that streams all registers out over a valid/ready channel, for bench checking and post-mortem inspection.
- Sits in the tinymips datapath between decode (A1/A2) and writeback (A3/WD3/WE3).
- Dump channel is consumed by the verification harness.

Parameters:
- NUM_REGS, 32, number of architectural registers. Must be a power of 2.
- ADDR_W, 5, register address width. Equals log2(NUM_REGS).
- DATA_W, 32, register width.
- HARDWIRE_R0, 0, when 1: register 0 always reads 0 and writes to it are dropped.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- A1  input  ADDR_W  read address, port 1.
- A2  input  ADDR_W  read address, port 2.
- A3  input  ADDR_W  write address.
- WD3  input  DATA_W  write data.
- WE3  input  1  write enable.
- RD1  output  DATA_W  read data, port 1.
- RD2  output  DATA_W  read data, port 2.
- DUMP_REQ  input  1  start-dump request, sampled in IDLE only.
- DUMP_VALID  output  1  dump beat valid.
- DUMP_READY  input  1  dump beat accepted.
- DUMP_ADDR  output  ADDR_W  register index of the current beat.
- DUMP_DATA  output  DATA_W  register value of the current beat.
- DUMP_DONE  output  1  one-cycle pulse after the last beat is accepted.
- DUMP_BUSY  output  1  high while the dump FSM is not IDLE.

Behaviour:
- Reset: RST_N low asynchronously clears all registers to 0, FSM to IDLE, and DUMP_VALID/DUMP_DONE/DUMP_BUSY/DUMP_ADDR/DUMP_DATA to 0. RD1/RD2 then read 0.
- Write: on rising CLK with WE3=1, reg[A3] <= WD3.
  - With HARDWIRE_R0=1 and A3=0, the write is ignored.
  - A write takes priority over nothing; there is a single writer.
- Read: RD1=reg[A1] and RD2=reg[A2], combinational, zero latency.
  - No write-to-read bypass: a same-cycle write is visible on RD only after the edge.
  - A1==A2 is legal; both ports return the same value.
- FSM states:
  - IDLE: DUMP_REQ=1 -> LOAD, idx<=0, DUMP_BUSY<=1.
  - LOAD (1 cycle): capture snapshot DUMP_DATA<=reg[idx], merged with the same-edge write (WE3 && A3==idx ? WD3 : reg[idx]); DUMP_ADDR<=idx; DUMP_VALID<=1. Next state SEND.
  - SEND: hold DUMP_ADDR/DUMP_DATA stable while DUMP_VALID && !DUMP_READY, even if reg[idx] is written meanwhile.
    - On DUMP_VALID && DUMP_READY with idx<NUM_REGS-1: idx<=idx+1, DUMP_VALID<=0, go to LOAD.
    - On handshake with idx==NUM_REGS-1: DUMP_VALID<=0, DUMP_DONE<=1 for one cycle, DUMP_BUSY<=0, go to IDLE.
- Throughput: one beat every 2 cycles with READY held high; a full dump takes 2*NUM_REGS cycles plus the DONE cycle.
- DUMP_REQ outside IDLE is ignored. It is not queued.
- idx counter is ADDR_W bits; terminal compare is against NUM_REGS-1, so no wrap.
- HARDWIRE_R0=1: beat 0 reports data 0.
- Reset asserted mid-dump aborts immediately. DUMP_DONE is not pulsed.
- The dump never blocks or delays register writes or reads.

Decomposition:
- Package tinymips_pkg holds:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32.
  - typedef reg_addr_t, reg_data_t.
  - enum dump_state_t {IDLE, LOAD, SEND}.
- Sub-module regfile_dump_fsm owns the state, idx, snapshot register and handshake outputs.
  - It gets array read access through an internal third read port (dump_addr -> dump_rdata) plus WE3/A3/WD3 for the same-edge merge.
- The storage array and RD1/RD2 stay in regfile_dbg.

Test Plan:
- Write/read: write 32'h5a5a5a5a to r0 and 32'h12345678 to r1, then A1=0, A2=1 -> RD1=5a5a5a5a, RD2=12345678 (HARDWIRE_R0=0). Swap the writes -> RD1=12345678, RD2=5a5a5a5a.
- Zero register: HARDWIRE_R0=1, write 32'hffffffff to r0 -> RD1=0 with A1=0. r1 write/read is unaffected.
- Async reset: fill r0..r31 with 32'h100+i, pulse RST_N low mid-cycle -> RD1/RD2=0 immediately with no clock; DUMP_* outputs are 0.
- Full dump: r_i=32'hA000_0000+i, DUMP_REQ pulse, READY=1 -> 32 beats (ADDR i, DATA A0000000+i), one DONE pulse, BUSY low after 65 cycles.
- Backpressure stability: hold READY=0 on beat 5 for 10 cycles while writing r5=32'hdeadbeef -> DUMP_DATA stays A0000005. A later dump shows deadbeef.
- Same-edge merge and abort: write r3=32'h0badf00d on the LOAD edge of beat 3 -> beat 3 data 0badf00d. Reset during beat 10 -> VALID=0, no DONE, new DUMP_REQ restarts at ADDR 0.
